// File: rtl/rgb444_pixel_packer.sv
// Camera byte-pair to RGB444 pixel packer with frame markers and geometry check.
// Bytes are qualified combinationally by href/byte_valid; vsync/href edges come from a one-deep sample history.
module rgb444_pixel_packer #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vsync,
  input  logic        href,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [11:0] data_out,
  output logic        pixel_valid,
  output logic        startofpacket,
  output logic        endofpacket,
  output logic        frame_error,
  output logic [15:0] frame_count
);

  localparam int COL_W = $clog2(IMG_WIDTH + 1);
  localparam int ROW_W = $clog2(IMG_HEIGHT + 2);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT);
  localparam logic [ROW_W-1:0] ROW_SAT = ROW_W'(IMG_HEIGHT + 1);

  typedef enum logic [1:0] {
    WAIT_VSYNC = 2'd0,
    BLANK      = 2'd1,
    FRAME      = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic             hr_q, hr_d, hr_prev_q, hr_prev_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             phase_q, phase_d;
  logic [3:0]       red_q, red_d;
  logic             err_q, err_d;
  logic [11:0]      data_q, data_d;
  logic             pv_q, pv_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             ferr_q, ferr_d;
  logic [15:0]      fcnt_q, fcnt_d;

  logic vs_rise, vs_fall, hr_fall, line_close, frame_bad;

  assign vs_rise = vs_q & ~vs_prev_q;
  assign vs_fall = ~vs_q & vs_prev_q;
  assign hr_fall = ~hr_q & hr_prev_q;
  // A vsync rise with the line still open closes that line first.
  assign line_close = hr_fall | (vs_rise & hr_q);

  always_comb begin
    state_d   = state_q;
    vs_d      = vsync;
    vs_prev_d = vs_q;
    hr_d      = href;
    hr_prev_d = hr_q;
    col_d     = col_q;
    row_d     = row_q;
    phase_d   = phase_q;
    red_d     = red_q;
    err_d     = err_q;
    data_d    = data_q;
    pv_d      = 1'b0;
    sop_d     = 1'b0;
    eop_d     = 1'b0;
    ferr_d    = ferr_q;
    fcnt_d    = fcnt_q;
    frame_bad = 1'b0;

    case (state_q)
      WAIT_VSYNC: begin
        if (vs_q) state_d = BLANK;
      end

      BLANK: begin
        if (vs_fall) begin
          sop_d   = 1'b1;
          col_d   = '0;
          row_d   = '0;
          phase_d = 1'b0;
          err_d   = 1'b0;
          state_d = FRAME;
        end
      end

      FRAME: begin
        if (line_close) begin
          if (col_q != COL_MAX || phase_q) err_d = 1'b1;
          if (row_q != ROW_SAT) row_d = row_q + ROW_W'(1);
          col_d   = '0;
          phase_d = 1'b0;
        end

        if (vs_rise) begin
          frame_bad = err_d | (row_d != ROW_MAX);
          err_d     = frame_bad;
          ferr_d    = frame_bad;
          eop_d     = 1'b1;
          fcnt_d    = fcnt_q + 16'd1;
          state_d   = BLANK;
        end else if (href && byte_valid) begin
          // Decisions use the post-close column/phase so a byte in the close cycle starts a fresh line.
          if (col_d >= COL_MAX || row_d >= ROW_MAX) begin
            err_d = 1'b1;
          end else if (!phase_d) begin
            red_d   = byte_in[3:0];
            phase_d = 1'b1;
          end else begin
            data_d  = {red_q, byte_in};
            pv_d    = 1'b1;
            phase_d = 1'b0;
            col_d   = col_q + COL_W'(1);
          end
        end
      end

      default: state_d = WAIT_VSYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= WAIT_VSYNC;
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      hr_q      <= 1'b0;
      hr_prev_q <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      phase_q   <= 1'b0;
      red_q     <= 4'd0;
      err_q     <= 1'b0;
      data_q    <= 12'd0;
      pv_q      <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      ferr_q    <= 1'b0;
      fcnt_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      vs_q      <= vs_d;
      vs_prev_q <= vs_prev_d;
      hr_q      <= hr_d;
      hr_prev_q <= hr_prev_d;
      col_q     <= col_d;
      row_q     <= row_d;
      phase_q   <= phase_d;
      red_q     <= red_d;
      err_q     <= err_d;
      data_q    <= data_d;
      pv_q      <= pv_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      ferr_q    <= ferr_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign data_out      = data_q;
  assign pixel_valid   = pv_q;
  assign startofpacket = sop_q;
  assign endofpacket   = eop_q;
  assign frame_error   = ferr_q;
  assign frame_count   = fcnt_q;

endmodule
